// File: rtl/guvm_feed_pkg.sv
// Shared types and constants for the GUVM instruction feeder.
// Also intended for the data-side responder that will reuse the same FIFO.
package guvm_feed_pkg;

    localparam int          FEED_ADDR_W = 32;
    localparam int          FEED_DATA_W = 32;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;  // addi x0,x0,0

    typedef enum logic {IDLE, RESP} resp_state_e;

    typedef struct packed {
        logic [FEED_ADDR_W-1:0] addr;
        logic [FEED_DATA_W-1:0] data;
    } fetch_rec_t;

endpackage

// File: rtl/guvm_sync_fifo.sv
// Synchronous FIFO with an explicit occupancy counter and a one-cycle flush.
// Head word is presented combinationally on pop_data_o.
module guvm_sync_fifo #(
    parameter int  DEPTH = 8,
    parameter int  WIDTH = 32,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LW-1:0]    level_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full_o     = (count == LW'(DEPTH));
    assign empty_o    = (count == '0);
    assign level_o    = count;
    assign pop_data_o = mem[rd_ptr];

    // Flush wins over both ports so a word pushed alongside it is dropped.
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + LW'(do_push) - LW'(do_pop);
        end
    end

    // Contents need no reset: an empty FIFO never exposes them.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= push_data_i;
    end

endmodule

// File: rtl/guvm_instr_feeder.sv
// OBI-style instruction responder fed by the GUVM driver: combinational grant,
// fixed one-cycle response, fetch address export and an underflow counter.
module guvm_instr_feeder
    import guvm_feed_pkg::*;
#(
    parameter int DEPTH          = 8,
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 32,
    parameter bit STALL_ON_EMPTY = 1'b1,
    parameter int CNT_W          = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_valid_i,
    input  logic [DATA_W-1:0]        push_data_i,
    output logic                     push_ready_o,
    input  logic                     flush_i,
    input  logic                     instr_req_i,
    input  logic [ADDR_W-1:0]        instr_addr_i,
    output logic                     instr_gnt_o,
    output logic                     instr_rvalid_o,
    output logic [DATA_W-1:0]        instr_rdata_o,
    output logic [ADDR_W-1:0]        fetch_addr_o,
    output logic                     fetch_addr_valid_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic [CNT_W-1:0]         underflow_cnt_o
);

    logic              full;
    logic              empty;
    logic [DATA_W-1:0] head;
    logic              gnt;
    logic              pop;
    logic              underflow;
    resp_state_e       state;

    assign gnt = instr_req_i && !flush_i && !rst_i && (!empty || !STALL_ON_EMPTY);
    assign pop = gnt && !empty;
    assign underflow = instr_req_i && empty && !flush_i;

    assign instr_gnt_o        = gnt;
    assign push_ready_o       = !full;
    assign instr_rvalid_o     = (state == RESP);
    assign fetch_addr_valid_o = (state == RESP);

    guvm_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push_valid_i),
        .push_data_i (push_data_i),
        .pop_i       (pop),
        .flush_i     (flush_i),
        .pop_data_o  (head),
        .full_o      (full),
        .empty_o     (empty),
        .level_o     (level_o)
    );

    // Response FSM: RESP is occupied exactly in the cycle after any grant.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            instr_rdata_o <= '0;
            fetch_addr_o  <= '0;
        end else begin
            case (state)
                IDLE:    if (gnt)  state <= RESP;
                RESP:    if (!gnt) state <= IDLE;
                default: state <= IDLE;
            endcase
            if (gnt) begin
                instr_rdata_o <= empty ? DATA_W'(NOP_INSTR) : head;
                fetch_addr_o  <= instr_addr_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            underflow_cnt_o <= '0;
        else if (underflow && !(&underflow_cnt_o))
            underflow_cnt_o <= underflow_cnt_o + CNT_W'(1);
    end

endmodule
